// File: rtl/branch_cmp_unit_pkg.sv
// Shared compare-mode encoding for the branch compare unit and its core.
package branch_cmp_unit_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] CMP_EQ  = 3'd0;
  localparam logic [MODE_W-1:0] CMP_NE  = 3'd1;
  localparam logic [MODE_W-1:0] CMP_LTZ = 3'd2;
  localparam logic [MODE_W-1:0] CMP_LEZ = 3'd3;
  localparam logic [MODE_W-1:0] CMP_GTZ = 3'd4;
  localparam logic [MODE_W-1:0] CMP_GEZ = 3'd5;
  localparam logic [MODE_W-1:0] CMP_LT  = 3'd6;
  localparam logic [MODE_W-1:0] CMP_LTU = 3'd7;

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch compare: evaluates one of eight modes on two operands.
module branch_cmp_core
  import branch_cmp_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [MODE_W-1:0] mode,
  output logic              taken
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    taken = 1'b0;
    case (mode)
      CMP_EQ:  taken = (a == b);
      CMP_NE:  taken = (a != b);
      CMP_LTZ: taken = a_neg;
      CMP_LEZ: taken = a_neg | a_zero;
      CMP_GTZ: taken = ~a_neg & ~a_zero;
      CMP_GEZ: taken = ~a_neg;
      CMP_LT:  taken = ($signed(a) < $signed(b));
      CMP_LTU: taken = (a < b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_unit.sv
// Pipelined branch compare unit (LATENCY 1 or 2) with stall/flush.
// Optional saturating result counters are enabled by defining BRANCH_CMP_STATS_EN.
module branch_cmp_unit
  import branch_cmp_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_taken,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  stat_eval,
  output logic [CNT_W-1:0]  stat_taken
);

  logic             advance;
  logic             core_taken;
  logic             ld_valid;
  logic [TAG_W-1:0] ld_tag;

  assign advance = ~stall & ~flush;

  if (LATENCY == 1) begin : g_lat1
    branch_cmp_core #(.WIDTH(WIDTH)) u_core (
      .a     (in_a),
      .b     (in_b),
      .mode  (in_mode),
      .taken (core_taken)
    );
    assign ld_valid = in_valid;
    assign ld_tag   = in_tag;
  end else begin : g_lat2
    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_a_q;
    logic [WIDTH-1:0]  s1_b_q;
    logic [MODE_W-1:0] s1_mode_q;
    logic [TAG_W-1:0]  s1_tag_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_valid_q <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
        s1_mode_q  <= '0;
        s1_tag_q   <= '0;
      end else if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (!stall) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q    <= in_a;
          s1_b_q    <= in_b;
          s1_mode_q <= in_mode;
          s1_tag_q  <= in_tag;
        end
      end
    end

    branch_cmp_core #(.WIDTH(WIDTH)) u_core (
      .a     (s1_a_q),
      .b     (s1_b_q),
      .mode  (s1_mode_q),
      .taken (core_taken)
    );
    assign ld_valid = s1_valid_q;
    assign ld_tag   = s1_tag_q;
  end

  logic             out_valid_q;
  logic             out_taken_q;
  logic [TAG_W-1:0] out_tag_q;

  // Taken is cleared alongside valid so a bubble or flush never shows a stale taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_tag_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= ld_valid;
      out_taken_q <= ld_valid & core_taken;
      if (ld_valid) begin
        out_tag_q <= ld_tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_taken = out_taken_q;
  assign out_tag   = out_tag_q;

`ifdef BRANCH_CMP_STATS_EN
  logic             load_evt;
  logic [CNT_W-1:0] eval_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  assign load_evt = advance & ld_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eval_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else if (load_evt) begin
      if (eval_cnt_q != '1) begin
        eval_cnt_q <= eval_cnt_q + 1'b1;
      end
      if (core_taken && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 1'b1;
      end
    end
  end

  assign stat_eval  = eval_cnt_q;
  assign stat_taken = taken_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign stat_eval      = '0;
  assign stat_taken     = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Scoreboard bench: LATENCY=1 (CNT_W=2) and LATENCY=2 instances share one stimulus stream.
module tb_branch_cmp_unit;
  import branch_cmp_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        stall;
  logic        flush;

  logic        o1_valid, o1_taken;
  logic [4:0]  o1_tag;
  logic [1:0]  s1_eval, s1_taken;
  logic        o2_valid, o2_taken;
  logic [4:0]  o2_tag;
  logic [15:0] s2_eval, s2_taken;

  typedef struct packed {
    logic       taken;
    logic [4:0] tag;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  logic load_edge;

  branch_cmp_unit #(.WIDTH(32), .LATENCY(1), .TAG_W(5), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag), .stall(stall), .flush(flush),
    .out_valid(o1_valid), .out_taken(o1_taken), .out_tag(o1_tag),
    .stat_eval(s1_eval), .stat_taken(s1_taken)
  );

  branch_cmp_unit #(.WIDTH(32), .LATENCY(2), .TAG_W(5), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag), .stall(stall), .flush(flush),
    .out_valid(o2_valid), .out_taken(o2_taken), .out_tag(o2_tag),
    .stat_eval(s2_eval), .stat_taken(s2_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Marks edges on which the output stage was allowed to load.
  always @(posedge clk) load_edge <= reset && !stall && !flush;

  always @(negedge clk) begin
    exp_t e;
    if (o1_valid && load_edge) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb_lat1: unexpected result tag %0d, none expected", o1_tag);
      end else begin
        e = q1.pop_front();
        if ({o1_taken, o1_tag} !== e) begin
          errors++;
          $display("FAIL sb_lat1: got taken=%0b tag=%0d, expected taken=%0b tag=%0d",
                   o1_taken, o1_tag, e.taken, e.tag);
        end
      end
    end
    if (o2_valid && load_edge) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb_lat2: unexpected result tag %0d, none expected", o2_tag);
      end else begin
        e = q2.pop_front();
        if ({o2_taken, o2_tag} !== e) begin
          errors++;
          $display("FAIL sb_lat2: got taken=%0b tag=%0d, expected taken=%0b tag=%0d",
                   o2_taken, o2_tag, e.taken, e.tag);
        end
      end
    end
    if (reset && !o1_valid) begin
      checks++;
      if (o1_taken !== 1'b0) begin
        errors++;
        $display("FAIL bubble_taken_lat1: got %0b, expected 0", o1_taken);
      end
    end
    if (reset && !o2_valid) begin
      checks++;
      if (o2_taken !== 1'b0) begin
        errors++;
        $display("FAIL bubble_taken_lat2: got %0b, expected 0", o2_taken);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] m);
    case (m)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < 0;
      3'd3:    return $signed(a) <= 0;
      3'd4:    return $signed(a) > 0;
      3'd5:    return $signed(a) >= 0;
      3'd6:    return $signed(a) < $signed(b);
      default: return a < b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                      input logic [4:0] t, input logic exp_taken);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_tag   = t;
    if (reset && !stall && !flush) begin
      q1.push_back({exp_taken, t});
      q2.push_back({exp_taken, t});
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle();
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d/%0d results outstanding, expected 0/0",
               name, q1.size(), q2.size());
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    stall = 1'b0; flush = 1'b0;
    repeat (3) step();
    checks++;
    if ({o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag});
    end
    checks++;
    if ({s1_eval, s1_taken, s2_eval, s2_taken} !== 36'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d %0d %0d %0d, expected 0",
               s1_eval, s1_taken, s2_eval, s2_taken);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    send(32'h1234, 32'h1234, CMP_EQ, 5'd3, 1'b1);
    step();
    send(32'h1234, 32'h1234, CMP_NE, 5'd4, 1'b0);
    checks++;
    if ({o1_valid, o1_taken, o1_tag, o2_valid} !== {1'b1, 1'b1, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_eq_timing: got v1=%0b t1=%0b tag1=%0d v2=%0b, expected 1 1 3 0",
               o1_valid, o1_taken, o1_tag, o2_valid);
    end
    step();
    idle();
    checks++;
    if ({o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag} !==
        {1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 5'd3}) begin
      errors++;
      $display("FAIL basic_ne_timing: got %0b %0b %0d %0b %0b %0d, expected 1 0 4 1 1 3",
               o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag);
    end
    drain("basic");
  endtask

  task automatic test_signed();
    logic [31:0] ta[15] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h1, 32'h5,
                            32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000};
    logic [31:0] tb[15] = '{32'h1, 32'h1, 32'hDEAD, 32'hBEEF, 32'h0,
                            32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h6,
                            32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h8000_0000};
    logic [2:0]  tm[15] = '{CMP_LT, CMP_LTU, CMP_LEZ, CMP_GTZ, CMP_GEZ,
                            CMP_LTZ, CMP_GTZ, CMP_LT, CMP_LTU, CMP_NE,
                            CMP_EQ, CMP_LEZ, CMP_GEZ, CMP_LTZ, CMP_LT};
    logic        te[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      send(ta[i], tb[i], tm[i], 5'(i + 10), te[i]);
      step();
    end
    drain("signed");
  endtask

  task automatic test_back_to_back();
    send(32'h7, 32'h7, CMP_EQ, 5'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      logic exp_v;
      step();
      if (i < 4) send(32'h7, 32'h7, (i % 2 == 1) ? CMP_NE : CMP_EQ, 5'(i + 1), i % 2 == 0);
      else idle();
      exp_v = (i >= 2 && i <= 5);
      checks++;
      if (o2_valid !== exp_v || (exp_v && o2_tag !== 5'(i - 1))) begin
        errors++;
        $display("FAIL b2b_edge%0d: got valid=%0b tag=%0d, expected valid=%0b tag=%0d",
                 i, o2_valid, o2_tag, exp_v, i - 1);
      end
    end
    drain("b2b");
  endtask

  task automatic test_stall();
    send(32'h55, 32'h55, CMP_EQ, 5'd5, 1'b1);
    step();
    send(32'h55, 32'h55, CMP_NE, 5'd6, 1'b0);
    step();
    stall = 1'b1;
    send(32'h1, 32'h2, CMP_LTU, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({o2_valid, o2_taken, o2_tag, o1_valid, o1_taken, o1_tag} !==
          {1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd6}) begin
        errors++;
        $display("FAIL stall_hold%0d: got %0b %0b %0d %0b %0b %0d, expected 1 1 5 1 0 6",
                 i, o2_valid, o2_taken, o2_tag, o1_valid, o1_taken, o1_tag);
      end
    end
    stall = 1'b0;
    idle();
    step();
    checks++;
    if ({o2_valid, o2_taken, o2_tag, o1_valid} !== {1'b1, 1'b0, 5'd6, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: got %0b %0b %0d v1=%0b, expected 1 0 6 0",
               o2_valid, o2_taken, o2_tag, o1_valid);
    end
    drain("stall");
  endtask

  task automatic test_flush();
    logic [1:0]  e1, t1;
    logic [15:0] e2, t2;
    send(32'h9, 32'h9, CMP_EQ, 5'd8, 1'b1);
    step();
    send(32'h9, 32'h9, CMP_EQ, 5'd9, 1'b1);
    step();
    flush = 1'b1;
    stall = 1'b1;
    send(32'h9, 32'h9, CMP_EQ, 5'd10, 1'b1);
    e1 = s1_eval; t1 = s1_taken; e2 = s2_eval; t2 = s2_taken;
    step();
    q1.delete();
    q2.delete();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    checks++;
    if ({o1_valid, o1_taken, o2_valid, o2_taken} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_clear: got v1=%0b t1=%0b v2=%0b t2=%0b, expected 0 0 0 0",
               o1_valid, o1_taken, o2_valid, o2_taken);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o1_valid !== 1'b0 || o2_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_nothing%0d: got v1=%0b v2=%0b, expected 0 0", i, o1_valid, o2_valid);
      end
    end
    checks++;
`ifdef BRANCH_CMP_STATS_EN
    if (s1_eval !== e1 || s1_taken !== t1 || s2_eval !== e2 || s2_taken !== t2) begin
      errors++;
      $display("FAIL flush_stats: got %0d %0d %0d %0d, expected %0d %0d %0d %0d",
               s1_eval, s1_taken, s2_eval, s2_taken, e1, t1, e2, t2);
    end
`else
    if ({s1_eval, s1_taken, s2_eval, s2_taken} !== 36'd0 || {e1, t1, e2, t2} !== 36'd0) begin
      errors++;
      $display("FAIL flush_stats_off: got %0d %0d %0d %0d, expected 0",
               s1_eval, s1_taken, s2_eval, s2_taken);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      logic [2:0]  m;
      int          pat;
      stall = ($urandom_range(0, 9) == 0);
      pat   = $urandom_range(0, 3);
      a     = $urandom();
      b     = $urandom();
      m     = 3'($urandom_range(0, 7));
      if (pat == 1) b = a;
      if (pat == 2) a = '0;
      if (pat == 3) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h8000_0000;
          1:       a = 32'h7FFF_FFFF;
          default: a = 32'hFFFF_FFFF;
        endcase
      end
      if ($urandom_range(0, 4) != 0) send(a, b, m, 5'(i), model(a, b, m));
      else idle();
      step();
    end
    stall = 1'b0;
    drain("random");
  endtask

  task automatic test_reset_mid();
    send(32'h3, 32'h3, CMP_EQ, 5'd11, 1'b1);
    step();
    send(32'h3, 32'h4, CMP_LT, 5'd12, 1'b1);
    step();
    send(32'h3, 32'h3, CMP_NE, 5'd13, 1'b0);
    checks++;
    if (o1_valid !== 1'b1 || o2_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got v1=%0b v2=%0b, expected 1 1", o1_valid, o2_valid);
    end
    #2;
    reset = 1'b0;
    idle();
    #1;
    q1.delete();
    q2.delete();
    checks++;
    if ({o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b, expected all zero",
               {o1_valid, o1_taken, o1_tag, o2_valid, o2_taken, o2_tag});
    end
    checks++;
    if ({s1_eval, s1_taken, s2_eval, s2_taken} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_stats: got %0d %0d %0d %0d, expected 0",
               s1_eval, s1_taken, s2_eval, s2_taken);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    checks++;
    if (o1_valid !== 1'b0 || o2_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got v1=%0b v2=%0b, expected 0 0", o1_valid, o2_valid);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      send(32'hA, 32'hA, CMP_EQ, 5'(20 + i), 1'b1);
      step();
    end
    drain("sat");
    checks++;
`ifdef BRANCH_CMP_STATS_EN
    if (s1_eval !== 2'd3 || s1_taken !== 2'd3 || s2_eval !== 16'd5 || s2_taken !== 16'd5) begin
      errors++;
      $display("FAIL sat_stats: got %0d %0d %0d %0d, expected 3 3 5 5",
               s1_eval, s1_taken, s2_eval, s2_taken);
    end
`else
    if ({s1_eval, s1_taken, s2_eval, s2_taken} !== 36'd0) begin
      errors++;
      $display("FAIL sat_stats_off: got %0d %0d %0d %0d, expected 0",
               s1_eval, s1_taken, s2_eval, s2_taken);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
